// File: rtl/default_slave_pkg.sv
// Shared AXI widths and response codes for the interconnect's default slave.
`ifndef AXI_IDS_BITS
`define AXI_IDS_BITS 8
`endif
`ifndef AXI_LEN_BITS
`define AXI_LEN_BITS 4
`endif
`ifndef AXI_DATA_BITS
`define AXI_DATA_BITS 32
`endif
`ifndef AXI_ADDR_BITS
`define AXI_ADDR_BITS 32
`endif
`ifndef AXI_SIZE_BITS
`define AXI_SIZE_BITS 3
`endif
`ifndef AXI_BURST_BITS
`define AXI_BURST_BITS 2
`endif
`ifndef AXI_STRB_BITS
`define AXI_STRB_BITS 4
`endif

package default_slave_pkg;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_DECERR = 2'b11;
endpackage

// File: rtl/default_slave.sv
// Default AXI slave: answers every unmapped read/write with DECERR, one transaction at a time.
// States: IDLE accept AW/AR (AW wins) | R_BURST DECERR read beats | W_DATA drain write data | W_RESP DECERR write response
module default_slave
  import default_slave_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst,
  input  logic [`AXI_IDS_BITS-1:0]    ARID_SD,
  input  logic [`AXI_ADDR_BITS-1:0]   ARADDR_SD,
  input  logic [`AXI_LEN_BITS-1:0]    ARLEN_SD,
  input  logic [`AXI_SIZE_BITS-1:0]   ARSIZE_SD,
  input  logic [`AXI_BURST_BITS-1:0]  ARBURST_SD,
  input  logic                        ARVALID_SD,
  output logic                        ARREADY_SD,
  input  logic [`AXI_IDS_BITS-1:0]    AWID_SD,
  input  logic [`AXI_ADDR_BITS-1:0]   AWADDR_SD,
  input  logic [`AXI_SIZE_BITS-1:0]   AWSIZE_SD,
  input  logic [`AXI_BURST_BITS-1:0]  AWBURST_SD,
  input  logic                        AWVALID_SD,
  output logic                        AWREADY_SD,
  input  logic [`AXI_DATA_BITS-1:0]   WDATA_SD,
  input  logic [`AXI_STRB_BITS-1:0]   WSTRB_SD,
  input  logic                        WLAST_SD,
  input  logic                        WVALID_SD,
  output logic                        WREADY_SD,
  output logic [`AXI_IDS_BITS-1:0]    BID_SD,
  output logic [1:0]                  BRESP_SD,
  output logic                        BVALID_SD,
  input  logic                        BREADY_SD,
  output logic [`AXI_IDS_BITS-1:0]    RID_SD,
  output logic [`AXI_DATA_BITS-1:0]   RDATA_SD,
  output logic [1:0]                  RRESP_SD,
  output logic                        RLAST_SD,
  output logic                        RVALID_SD,
  input  logic                        RREADY_SD
);

  typedef enum logic [1:0] {IDLE, R_BURST, W_DATA, W_RESP} state_e;

  state_e                     state_q, state_d;
  logic [`AXI_IDS_BITS-1:0]   id_q, id_d;
  logic [`AXI_LEN_BITS-1:0]   len_q, len_d;
  logic [`AXI_LEN_BITS-1:0]   beat_q, beat_d;
  logic                       last_beat;

  assign last_beat = (beat_q == len_q);

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    len_d   = len_q;
    beat_d  = beat_q;
    case (state_q)
      IDLE: begin
        if (AWVALID_SD) begin
          id_d    = AWID_SD;
          state_d = W_DATA;
        end else if (ARVALID_SD) begin
          id_d    = ARID_SD;
          len_d   = ARLEN_SD;
          beat_d  = '0;
          state_d = R_BURST;
        end
      end
      R_BURST: begin
        if (RREADY_SD) begin
          if (last_beat) state_d = IDLE;
          else           beat_d  = beat_q + 1'b1;
        end
      end
      W_DATA: begin
        if (WVALID_SD && WLAST_SD) state_d = W_RESP;
      end
      W_RESP: begin
        if (BREADY_SD) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      id_q    <= '0;
      len_q   <= '0;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      len_q   <= len_d;
      beat_q  <= beat_d;
    end
  end

  // Write address always outranks read address while idle.
  assign AWREADY_SD = (state_q == IDLE);
  assign ARREADY_SD = (state_q == IDLE) && !AWVALID_SD;
  assign WREADY_SD  = (state_q == W_DATA);

  assign BVALID_SD  = (state_q == W_RESP);
  assign BID_SD     = BVALID_SD ? id_q : '0;
  assign BRESP_SD   = BVALID_SD ? RESP_DECERR : RESP_OKAY;

  assign RVALID_SD  = (state_q == R_BURST);
  assign RID_SD     = RVALID_SD ? id_q : '0;
  assign RRESP_SD   = RVALID_SD ? RESP_DECERR : RESP_OKAY;
  assign RLAST_SD   = RVALID_SD && last_beat;
  assign RDATA_SD   = '0;

  logic unused_inputs;
  assign unused_inputs = ^{ARADDR_SD, ARSIZE_SD, ARBURST_SD,
                           AWADDR_SD, AWSIZE_SD, AWBURST_SD, WDATA_SD, WSTRB_SD};

endmodule

// File: tb/tb_default_slave.sv
// Bench for default_slave: directed vector table, hand sequences, and a randomized model check.
`ifndef AXI_IDS_BITS
`define AXI_IDS_BITS 8
`endif
`ifndef AXI_LEN_BITS
`define AXI_LEN_BITS 4
`endif
`ifndef AXI_DATA_BITS
`define AXI_DATA_BITS 32
`endif
`ifndef AXI_ADDR_BITS
`define AXI_ADDR_BITS 32
`endif
`ifndef AXI_SIZE_BITS
`define AXI_SIZE_BITS 3
`endif
`ifndef AXI_BURST_BITS
`define AXI_BURST_BITS 2
`endif
`ifndef AXI_STRB_BITS
`define AXI_STRB_BITS 4
`endif

module tb_default_slave;

  logic clk, rst;
  logic [`AXI_IDS_BITS-1:0]   ARID_SD, AWID_SD, BID_SD, RID_SD;
  logic [`AXI_ADDR_BITS-1:0]  ARADDR_SD, AWADDR_SD;
  logic [`AXI_LEN_BITS-1:0]   ARLEN_SD;
  logic [`AXI_SIZE_BITS-1:0]  ARSIZE_SD, AWSIZE_SD;
  logic [`AXI_BURST_BITS-1:0] ARBURST_SD, AWBURST_SD;
  logic [`AXI_DATA_BITS-1:0]  WDATA_SD, RDATA_SD;
  logic [`AXI_STRB_BITS-1:0]  WSTRB_SD;
  logic ARVALID_SD, ARREADY_SD, AWVALID_SD, AWREADY_SD;
  logic WLAST_SD, WVALID_SD, WREADY_SD;
  logic [1:0] BRESP_SD, RRESP_SD;
  logic BVALID_SD, BREADY_SD, RLAST_SD, RVALID_SD, RREADY_SD;

  default_slave dut (
    .clk(clk), .rst(rst),
    .ARID_SD(ARID_SD), .ARADDR_SD(ARADDR_SD), .ARLEN_SD(ARLEN_SD), .ARSIZE_SD(ARSIZE_SD),
    .ARBURST_SD(ARBURST_SD), .ARVALID_SD(ARVALID_SD), .ARREADY_SD(ARREADY_SD),
    .AWID_SD(AWID_SD), .AWADDR_SD(AWADDR_SD), .AWSIZE_SD(AWSIZE_SD), .AWBURST_SD(AWBURST_SD),
    .AWVALID_SD(AWVALID_SD), .AWREADY_SD(AWREADY_SD),
    .WDATA_SD(WDATA_SD), .WSTRB_SD(WSTRB_SD), .WLAST_SD(WLAST_SD), .WVALID_SD(WVALID_SD),
    .WREADY_SD(WREADY_SD),
    .BID_SD(BID_SD), .BRESP_SD(BRESP_SD), .BVALID_SD(BVALID_SD), .BREADY_SD(BREADY_SD),
    .RID_SD(RID_SD), .RDATA_SD(RDATA_SD), .RRESP_SD(RRESP_SD), .RLAST_SD(RLAST_SD),
    .RVALID_SD(RVALID_SD), .RREADY_SD(RREADY_SD)
  );

  typedef struct packed {
    logic                      arready, awready, wready, bvalid;
    logic [`AXI_IDS_BITS-1:0]  bid;
    logic [1:0]                bresp;
    logic                      rvalid;
    logic [`AXI_IDS_BITS-1:0]  rid;
    logic [`AXI_DATA_BITS-1:0] rdata;
    logic [1:0]                rresp;
    logic                      rlast;
  } outs_t;

  typedef struct packed {
    logic                      arvalid;
    logic [`AXI_IDS_BITS-1:0]  arid;
    logic [`AXI_LEN_BITS-1:0]  arlen;
    logic                      awvalid;
    logic [`AXI_IDS_BITS-1:0]  awid;
    logic                      wvalid, wlast, bready, rready;
  } ins_t;

  typedef struct {
    ins_t  i;
    outs_t o;
  } vec_t;

  vec_t tbl[$];
  int   n_chk = 0;
  int   n_fail = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic ins_t mk_in(logic arv, logic [7:0] arid, logic [3:0] arlen, logic awv,
                                 logic [7:0] awid, logic wv, logic wl, logic br, logic rr);
    ins_t v;
    v.arvalid = arv; v.arid = arid; v.arlen = arlen; v.awvalid = awv; v.awid = awid;
    v.wvalid = wv; v.wlast = wl; v.bready = br; v.rready = rr;
    return v;
  endfunction

  // Expected outputs: responses are always DECERR while valid, zero otherwise; RDATA is always zero.
  function automatic outs_t mk_out(logic arr, logic awr, logic wr, logic bv, logic [7:0] bid,
                                   logic rv, logic [7:0] rid, logic rl);
    outs_t o;
    o.arready = arr; o.awready = awr; o.wready = wr;
    o.bvalid = bv; o.bid = bid; o.bresp = bv ? 2'b11 : 2'b00;
    o.rvalid = rv; o.rid = rid; o.rresp = rv ? 2'b11 : 2'b00; o.rlast = rl;
    o.rdata = '0;
    return o;
  endfunction

  function automatic outs_t smp();
    outs_t o;
    o.arready = ARREADY_SD; o.awready = AWREADY_SD; o.wready = WREADY_SD;
    o.bvalid = BVALID_SD; o.bid = BID_SD; o.bresp = BRESP_SD;
    o.rvalid = RVALID_SD; o.rid = RID_SD; o.rdata = RDATA_SD; o.rresp = RRESP_SD;
    o.rlast = RLAST_SD;
    return o;
  endfunction

  task automatic add(ins_t i, outs_t o);
    vec_t v;
    v.i = i; v.o = o;
    tbl.push_back(v);
  endtask

  task automatic drive(ins_t v);
    ARVALID_SD = v.arvalid; ARID_SD = v.arid; ARLEN_SD = v.arlen;
    AWVALID_SD = v.awvalid; AWID_SD = v.awid;
    WVALID_SD = v.wvalid; WLAST_SD = v.wlast;
    BREADY_SD = v.bready; RREADY_SD = v.rready;
  endtask

  task automatic check(string nm, outs_t act, outs_t exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic check_val(string nm, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  ins_t  idle_in;
  outs_t idle_out, o, prev_o, exp;
  int    beats;
  logic  rr, prev_rr, done;
  int    r_left, w_ph;
  logic [`AXI_IDS_BITS-1:0] m_id;
  ins_t  r;
  logic  m_idle;

  initial begin
    idle_in  = mk_in(1'b0, 8'h00, 4'd0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    idle_out = mk_out(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);

    // Single read, LEN=3, RREADY held high.
    add(mk_in(1'b1, 8'h15, 4'd3, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1), idle_out);
    for (int k = 0; k < 4; k++)
      add(mk_in(1'b0, 8'h00, 4'd0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1),
          mk_out(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'h15, (k == 3)));
    add(idle_in, idle_out);
    // Write, three data beats, BREADY held low for five cycles.
    add(mk_in(1'b0, 8'h00, 4'd0, 1'b1, 8'h22, 1'b0, 1'b0, 1'b0, 1'b0),
        mk_out(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0));
    for (int k = 0; k < 3; k++)
      add(mk_in(1'b0, 8'h00, 4'd0, 1'b0, 8'h00, 1'b1, (k == 2), 1'b0, 1'b0),
          mk_out(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0));
    for (int k = 0; k < 6; k++)
      add(mk_in(1'b0, 8'h00, 4'd0, 1'b0, 8'h00, 1'b0, 1'b0, (k == 5), 1'b0),
          mk_out(1'b0, 1'b0, 1'b0, 1'b1, 8'h22, 1'b0, 8'h00, 1'b0));
    add(idle_in, idle_out);
    // AW and AR together: write served first, read only after the B handshake.
    add(mk_in(1'b1, 8'h44, 4'd0, 1'b1, 8'h31, 1'b0, 1'b0, 1'b0, 1'b0),
        mk_out(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0));
    add(mk_in(1'b1, 8'h44, 4'd0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0),
        mk_out(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0));
    add(mk_in(1'b1, 8'h44, 4'd0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0),
        mk_out(1'b0, 1'b0, 1'b0, 1'b1, 8'h31, 1'b0, 8'h00, 1'b0));
    add(mk_in(1'b1, 8'h44, 4'd0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0), idle_out);
    add(mk_in(1'b0, 8'h00, 4'd0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1),
        mk_out(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'h44, 1'b1));
    add(idle_in, idle_out);

    ARADDR_SD = '0; ARSIZE_SD = '0; ARBURST_SD = '0;
    AWADDR_SD = '0; AWSIZE_SD = '0; AWBURST_SD = '0;
    WDATA_SD = '0; WSTRB_SD = '0;
    drive(idle_in);
    rst = 1'b0;
    #1;
    check("reset_state", smp(), idle_out);
    #11 rst = 1'b1;
    next_cycle();

    foreach (tbl[k]) begin
      drive(tbl[k].i);
      #2;
      check($sformatf("vec%0d", k), smp(), tbl[k].o);
      next_cycle();
    end

    // LEN=15 with RREADY toggling: 16 accepted beats, frozen outputs while RREADY=0.
    drive(mk_in(1'b1, 8'h77, 4'd15, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0));
    #2;
    check("len15_arready", smp(), idle_out);
    next_cycle();
    beats = 0; prev_rr = 1'b1; done = 1'b0; prev_o = '0;
    for (int cyc = 0; cyc < 80 && !done; cyc++) begin
      rr = (cyc % 2 == 1);
      drive(mk_in(1'b0, 8'h00, 4'd0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, rr));
      #2;
      o = smp();
      if (!prev_rr) check("len15_frozen", o, prev_o);
      check("len15_beat", o, mk_out(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'h77, (beats == 15)));
      if (rr) begin
        beats++;
        if (beats == 16) done = 1'b1;
      end
      prev_o = o; prev_rr = rr;
      next_cycle();
    end
    check_val("len15_beats", beats, 16);
    drive(idle_in);
    #2;
    check("len15_done_idle", smp(), idle_out);
    next_cycle();

    // Reset during beat 2 of a LEN=7 read, then a single-beat read.
    drive(mk_in(1'b1, 8'h66, 4'd7, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1));
    next_cycle();
    drive(mk_in(1'b0, 8'h00, 4'd0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1));
    next_cycle();
    #2;
    check("abort_beat2", smp(), mk_out(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'h66, 1'b0));
    rst = 1'b0;
    #1;
    check("abort_immediate", smp(), idle_out);
    next_cycle();
    check("abort_held", smp(), idle_out);
    rst = 1'b1;
    next_cycle();
    drive(mk_in(1'b1, 8'h5a, 4'd0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1));
    #2;
    check("post_rst_ar", smp(), idle_out);
    next_cycle();
    drive(mk_in(1'b0, 8'h00, 4'd0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1));
    #2;
    check("post_rst_beat", smp(), mk_out(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'h5a, 1'b1));
    next_cycle();
    drive(idle_in);
    #2;
    check("post_rst_idle", smp(), idle_out);
    next_cycle();

    // Random traffic against a transaction-level model: remaining read beats and write phase.
    r_left = 0; w_ph = 0; m_id = '0;
    for (int c = 0; c < 2000; c++) begin
      r.arvalid = (($urandom % 3) == 0);
      r.arid    = 8'($urandom);
      r.arlen   = 4'($urandom);
      r.awvalid = (($urandom % 4) == 0);
      r.awid    = 8'($urandom);
      r.wvalid  = (($urandom % 3) != 0);
      r.wlast   = (($urandom % 4) == 0);
      r.bready  = (($urandom % 2) == 0);
      r.rready  = (($urandom % 4) != 0);
      ARADDR_SD = $urandom; AWADDR_SD = $urandom; WDATA_SD = $urandom;
      ARSIZE_SD = 3'($urandom); AWSIZE_SD = 3'($urandom);
      ARBURST_SD = 2'($urandom); AWBURST_SD = 2'($urandom); WSTRB_SD = 4'($urandom);
      drive(r);
      #2;
      m_idle = (r_left == 0) && (w_ph == 0);
      exp = mk_out(m_idle && !r.awvalid, m_idle, (w_ph == 1),
                   (w_ph == 2), (w_ph == 2) ? m_id : 8'h00,
                   (r_left > 0), (r_left > 0) ? m_id : 8'h00, (r_left == 1));
      check("random", smp(), exp);
      if (m_idle) begin
        if (r.awvalid) begin
          m_id = r.awid; w_ph = 1;
        end else if (r.arvalid) begin
          m_id = r.arid; r_left = int'(r.arlen) + 1;
        end
      end else if (r_left > 0) begin
        if (r.rready) r_left--;
      end else if (w_ph == 1) begin
        if (r.wvalid && r.wlast) w_ph = 2;
      end else if (r.bready) begin
        w_ph = 0;
      end
      next_cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
